boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Sequences the boot-time copy of the program image from the instruction ROM into RAM.
- Sits directly upstream of the ROM. It drives the ROM's boot enable and address, then samples the shared data bus.
- Writes each word into RAM at the same address, holds the CPU until the copy completes, then releases the bus.
- The CPU begins fetching from RAM address 0 only after done.

Parameters:
- BOOT_WORDS, 16, number of 16-bit words copied; legal range 1..2^(`ADDR_SIZE-1).
- ADDR_STEP, 2, address increment per word (byte-addressed, word-sized bus).
- BASE_ADDR, 0, first ROM/RAM address copied.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a copy
- boot  output  1  ROM output enable; ROM drives data bus only while high
- rom_addr  output  `ADDR_SIZE  address presented to ROM
- bus_data  input  `WORD_SIZE  shared data bus, sampled only (never driven by this block)
- ram_addr  output  `ADDR_SIZE  RAM write address
- ram_wdata  output  `WORD_SIZE  RAM write data
- ram_wr_en  output  1  single-cycle RAM write strobe
- cpu_hold  output  1  holds CPU in reset while high
- busy  output  1  copy in progress
- done  output  1  copy completed; level, held until next start or reset

Behaviour:
- Reset values:
  - boot=0, rom_addr=0, ram_addr=0, ram_wdata=0, ram_wr_en=0
  - cpu_hold=1, busy=0, done=0
  - internal word counter=0, state=IDLE
- States: IDLE, ADDR, READ, WRITE, DONE.
- IDLE:
  - start=1 → ADDR; rom_addr=BASE_ADDR; counter=0; busy=1; boot=1.
- ADDR:
  - boot=1 and rom_addr stable for one full cycle so the combinational ROM settles → READ.
- READ:
  - ram_wdata<=bus_data; ram_addr<=rom_addr → WRITE.
- WRITE:
  - ram_wr_en=1 for exactly this cycle; boot stays high.
  - If counter==BOOT_WORDS-1 → DONE.
  - Otherwise counter+1, rom_addr+=ADDR_STEP → ADDR.
- DONE:
  - boot=0, busy=0, done=1.
  - cpu_hold drops to 0 on the same edge that enters DONE.
  - start=1 restarts the copy: done=0, cpu_hold=1, → ADDR.
- Latency: 3 cycles per word. done rises 3*BOOT_WORDS+1 cycles after the start edge.
- start while busy is ignored.
- Address arithmetic is modulo 2^`ADDR_SIZE. Wrap past the top address is a parameter error; flag it with an elaboration-time assertion, not in hardware.
- boot is never high in IDLE or DONE; ram_wr_en is never high outside WRITE.
- Reset mid-copy:
  - Takes effect on the next edge and returns to IDLE with reset values.
  - The partially written RAM is left as-is.
  - cpu_hold stays 1 until a full copy completes.
- reset and start asserted together: reset wins.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Enabled:
  - Adds output checksum [`WORD_SIZE], a running 16-bit modulo-2^16 sum of every word sampled in READ.
  - Cleared on reset and on each accepted start.
  - Valid when done=1.
- Disabled: port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package boot_pkg:
  - boot_state_t enum (IDLE, ADDR, READ, WRITE, DONE)
  - localparam for the default ADDR_STEP
- `ADDR_SIZE and `WORD_SIZE come from top_macro.vh.
- Single module. The word counter and address generator are too small to justify a sub-module.

Test Plan:
- Bench ROM model holds words 0x1205, 0x1312, ...; BOOT_WORDS=4, start pulse → rom_addr sequence 0,2,4,6; ram_wr_en pulses at cycles 3,6,9,12; RAM[0..6] matches ROM; done=1 at cycle 13.
- Boot bus check → boot=1 only from cycle 1 to cycle 12; bus_data sampled during ADDR is never written.
- Reset asserted in the WRITE of word 2 → next cycle all outputs at reset values, cpu_hold=1. A new start copies all 4 words from address 0.
- start pulses at cycles 2 and 5 during a copy → ignored; completion timing unchanged. start in DONE → done clears, copy repeats.
- BOOT_WORDS=1, BASE_ADDR=18, ROM[18]=0x8000 → single write of 0x8000 to RAM[18]; done at cycle 4.
- With BOOT_CHECKSUM_EN, words 0x8000, 0x8000, 0x0001 → checksum=0x0001 (wrap-around) when done=1.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and defaults for the boot-time ROM-to-RAM copier.
// ADDR_SIZE / WORD_SIZE normally come from top_macro.vh; fall back to 16 bits if not yet defined.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        WRITE,
        DONE
    } boot_state_t;

    localparam int DEFAULT_ADDR_STEP  = 2;
    localparam int DEFAULT_BOOT_WORDS = 16;
    localparam int DEFAULT_BASE_ADDR  = 0;

    // Byte address of the last word copied, computed wide enough to expose any wrap.
    function automatic longint last_copy_addr(input int base, input int words, input int step);
        return longint'(base) + longint'(words - 1) * longint'(step);
    endfunction

endpackage

// File: rtl/boot_loader.sv
// Copies BOOT_WORDS words from the instruction ROM into RAM at reset time, holding the CPU until done.
// Optional macro BOOT_CHECKSUM_EN adds a running modulo-2^WORD_SIZE checksum output.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module boot_loader
    import boot_pkg::*;
#(
    parameter int BOOT_WORDS = DEFAULT_BOOT_WORDS,
    parameter int ADDR_STEP  = DEFAULT_ADDR_STEP,
    parameter int BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   boot,
    output logic [`ADDR_SIZE-1:0]  rom_addr,
    input  logic [`WORD_SIZE-1:0]  bus_data,
    output logic [`ADDR_SIZE-1:0]  ram_addr,
    output logic [`WORD_SIZE-1:0]  ram_wdata,
    output logic                   ram_wr_en,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [`WORD_SIZE-1:0]  checksum
`endif
);

    localparam int     AW        = `ADDR_SIZE;
    localparam longint ADDR_SPAN = longint'(1) << AW;

    localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);
    localparam logic [AW-1:0] STEP     = AW'(ADDR_STEP);
    localparam logic [AW-1:0] LAST_CNT = AW'(BOOT_WORDS - 1);

    // Bad parameter sets are rejected at elaboration; the hardware never checks for wrap.
    generate
        if (BOOT_WORDS < 1 || longint'(BOOT_WORDS) > (ADDR_SPAN >> 1)) begin : g_bad_words
            $error("boot_loader: BOOT_WORDS=%0d outside 1..2^(ADDR_SIZE-1)", BOOT_WORDS);
        end
        if (last_copy_addr(BASE_ADDR, BOOT_WORDS, ADDR_STEP) >= ADDR_SPAN) begin : g_addr_wrap
            $error("boot_loader: copy window starting at %0d wraps past the top address", BASE_ADDR);
        end
    endgenerate

    boot_state_t   state;
    boot_state_t   state_next;
    logic [AW-1:0] word_cnt;
    logic          last_word;
    logic          start_accept;

    assign last_word = (word_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked branch, not in the sensitivity list.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here is defaulted first, so no path through the case can infer a latch.
        state_next   = state;
        start_accept = 1'b0;
        boot         = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        cpu_hold     = 1'b1;
        ram_wr_en    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = ADDR;
                end
            end
            ADDR: begin
                boot       = 1'b1;
                busy       = 1'b1;
                state_next = READ;
            end
            READ: begin
                boot       = 1'b1;
                busy       = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                boot       = 1'b1;
                busy       = 1'b1;
                ram_wr_en  = 1'b1;
                state_next = last_word ? DONE : ADDR;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = ADDR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address generator and capture registers; the ROM address is held through ADDR so the bus settles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr  <= '0;
            word_cnt  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            // NOTE: non-blocking updates let READ capture the rom_addr from before this edge.
            if (start_accept) begin
                rom_addr <= BASE;
                word_cnt <= '0;
            end else if (state == WRITE && !last_word) begin
                rom_addr <= rom_addr + STEP;
                word_cnt <= word_cnt + AW'(1);
            end
            if (state == READ) begin
                ram_wdata <= bus_data;
                ram_addr  <= rom_addr;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            checksum <= '0;
        end else if (state == READ) begin
            checksum <= checksum + bus_data;
        end
    end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a cycle-count model of the copy plus directed literal checks.
// Exercises the checksum output as well when BOOT_CHECKSUM_EN is defined.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_boot_loader;

    localparam int AW        = `ADDR_SIZE;
    localparam int WW        = `WORD_SIZE;
    localparam int N_MAIN    = 4;
    localparam int BASE_MAIN = 0;
    localparam int STEP      = 2;
    localparam int M_OFF     = -1;
    localparam int M_IDLE    = 0;
    localparam int M_COPY    = 1;
    localparam int M_DONE    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start = 1'b0;

    logic          boot, ram_wr_en, cpu_hold, busy, done;
    logic [AW-1:0] rom_addr, ram_addr;
    logic [WW-1:0] bus_data, ram_wdata;

    logic          boot1, ram_wr_en1, cpu_hold1, busy1, done1;
    logic [AW-1:0] rom_addr1, ram_addr1;
    logic [WW-1:0] bus_data1, ram_wdata1;

`ifdef BOOT_CHECKSUM_EN
    logic [WW-1:0] checksum, checksum1, checksum3;
    logic          boot3, ram_wr_en3, cpu_hold3, busy3, done3;
    logic [AW-1:0] rom_addr3, ram_addr3;
    logic [WW-1:0] bus_data3, ram_wdata3;
`endif

    boot_loader #(.BOOT_WORDS(N_MAIN), .ADDR_STEP(STEP), .BASE_ADDR(BASE_MAIN)) dut (
        .clk(clk), .reset(reset), .start(start), .boot(boot), .rom_addr(rom_addr),
        .bus_data(bus_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr_en(ram_wr_en),
        .cpu_hold(cpu_hold), .busy(busy), .done(done)
`ifdef BOOT_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    boot_loader #(.BOOT_WORDS(1), .ADDR_STEP(STEP), .BASE_ADDR(18)) dut1 (
        .clk(clk), .reset(reset), .start(start), .boot(boot1), .rom_addr(rom_addr1),
        .bus_data(bus_data1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_wr_en(ram_wr_en1),
        .cpu_hold(cpu_hold1), .busy(busy1), .done(done1)
`ifdef BOOT_CHECKSUM_EN
        , .checksum(checksum1)
`endif
    );

`ifdef BOOT_CHECKSUM_EN
    boot_loader #(.BOOT_WORDS(3), .ADDR_STEP(STEP), .BASE_ADDR(18)) dut3 (
        .clk(clk), .reset(reset), .start(start), .boot(boot3), .rom_addr(rom_addr3),
        .bus_data(bus_data3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_wr_en(ram_wr_en3),
        .cpu_hold(cpu_hold3), .busy(busy3), .done(done3), .checksum(checksum3)
    );
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ROM image indexed by word (byte address / 2); unused slots hold recognisable filler.
    logic [WW-1:0] rom_mem [0:31];
    logic [WW-1:0] ram_model [0:31];

    // The ROM only presents valid data once its address has been held for a full cycle.
    function automatic logic [WW-1:0] bus_val(input logic b, input logic pb,
                                              input logic [AW-1:0] a, input logic [AW-1:0] pa);
        return (b === 1'b1 && pb === 1'b1 && a === pa) ? rom_mem[a[5:1]] : WW'(16'hDEAD);
    endfunction

    logic          pb0 = 1'b0, pb1 = 1'b0, pb3 = 1'b0;
    logic [AW-1:0] pa0 = '0, pa1 = '0, pa3 = '0;

    always @(negedge clk) begin
        bus_data  = bus_val(boot, pb0, rom_addr, pa0);
        pb0 = boot;  pa0 = rom_addr;
        bus_data1 = bus_val(boot1, pb1, rom_addr1, pa1);
        pb1 = boot1; pa1 = rom_addr1;
`ifdef BOOT_CHECKSUM_EN
        bus_data3 = bus_val(boot3, pb3, rom_addr3, pa3);
        pb3 = boot3; pa3 = rom_addr3;
`endif
    end

    // Model: tracks cycles since the accepted start edge; cycle p of a copy belongs to word (p-1)/3.
    int            mode       = M_OFF;
    int            phase      = 0;
    int            edge_cnt   = 0;
    int            start_edge = 0;
    logic [WW-1:0] model_cs   = '0;

    function automatic logic [AW-1:0] exp_addr(input int p);
        return AW'(BASE_MAIN + ((p - 1) / 3) * STEP);
    endfunction

    always @(posedge clk) begin
        edge_cnt++;
        if (reset) begin
            mode = M_IDLE; phase = 0; model_cs = '0;
        end else if (start && mode != M_COPY) begin
            mode = M_COPY; phase = 1; model_cs = '0; start_edge = edge_cnt - 1;
        end else if (mode == M_COPY) begin
            if (phase % 3 == 2) model_cs = model_cs + rom_mem[exp_addr(phase) >> 1];
            if (phase == 3 * N_MAIN) mode = M_DONE;
            else phase++;
        end
    end

    // Compare process: every cycle the model is live, all main outputs are checked.
    logic [AW-1:0] cmp_addr;
    always @(negedge clk) begin
        if (mode == M_IDLE) begin
            check("idle_boot", boot, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_cpu_hold", cpu_hold, 1);
            check("idle_wr_en", ram_wr_en, 0);
            check("idle_rom_addr", rom_addr, 0);
            check("idle_ram_addr", ram_addr, 0);
            check("idle_ram_wdata", ram_wdata, 0);
        end else if (mode == M_COPY) begin
            cmp_addr = exp_addr(phase);
            check("copy_boot", boot, 1);
            check("copy_busy", busy, 1);
            check("copy_done", done, 0);
            check("copy_cpu_hold", cpu_hold, 1);
            check("copy_rom_addr", rom_addr, cmp_addr);
            check("copy_wr_en", ram_wr_en, (phase % 3 == 0) ? 1 : 0);
            if (phase % 3 == 0) begin
                check("write_ram_addr", ram_addr, cmp_addr);
                check("write_ram_wdata", ram_wdata, rom_mem[cmp_addr[5:1]]);
            end
        end else if (mode == M_DONE) begin
            check("done_boot", boot, 0);
            check("done_busy", busy, 0);
            check("done_done", done, 1);
            check("done_cpu_hold", cpu_hold, 0);
            check("done_wr_en", ram_wr_en, 0);
`ifdef BOOT_CHECKSUM_EN
            check("done_checksum", checksum, model_cs);
`endif
        end
    end

    // Recorders: act as the RAM and log event timing relative to the start edge.
    int   wr_cycles [$];
    int   boot_first, boot_last, done_cycle;
    int   wr1_count, wr1_cycle, done1_cycle;
    logic [AW-1:0] wr1_addr;
    logic [WW-1:0] wr1_data;
    logic prev_done = 1'b0, prev_done1 = 1'b0;

    task automatic clear_rec();
        wr_cycles.delete();
        boot_first = -1; boot_last = -1; done_cycle = -1;
        wr1_count = 0; wr1_cycle = -1; done1_cycle = -1;
        wr1_addr = '0; wr1_data = '0;
        for (int i = 0; i < 32; i++) ram_model[i] = '0;
    endtask

    always @(negedge clk) begin
        int rel;
        rel = edge_cnt - start_edge;
        if (ram_wr_en === 1'b1) begin
            ram_model[ram_addr[5:1]] = ram_wdata;
            wr_cycles.push_back(rel);
        end
        if (boot === 1'b1) begin
            if (boot_first < 0) boot_first = rel;
            boot_last = rel;
        end
        if (done === 1'b1 && prev_done !== 1'b1 && done_cycle < 0) done_cycle = rel;
        prev_done = done;
        if (ram_wr_en1 === 1'b1) begin
            wr1_count++; wr1_cycle = rel; wr1_addr = ram_addr1; wr1_data = ram_wdata1;
        end
        if (done1 === 1'b1 && prev_done1 !== 1'b1 && done1_cycle < 0) done1_cycle = rel;
        prev_done1 = done1;
    end

    task automatic pulse_start();
        @(negedge clk);
        clear_rec();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("done_within_bound", done, 1);
        #1;
    endtask

    task automatic check_full_copy(input string tag);
        int exp_wr [4] = '{3, 6, 9, 12};
        logic [WW-1:0] exp_word [4] = '{16'h1205, 16'h1312, 16'h141F, 16'h152C};
        check({tag, "_write_count"}, wr_cycles.size(), 4);
        for (int i = 0; i < 4 && i < wr_cycles.size(); i++)
            check({tag, "_write_cycle"}, wr_cycles[i], exp_wr[i]);
        check({tag, "_done_cycle"}, done_cycle, 13);
        for (int i = 0; i < 4; i++)
            check({tag, "_ram_word"}, ram_model[i], exp_word[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = WW'(16'h00A0 + i);
        rom_mem[0]  = 16'h1205;
        rom_mem[1]  = 16'h1312;
        rom_mem[2]  = 16'h141F;
        rom_mem[3]  = 16'h152C;
        rom_mem[9]  = 16'h8000;
        rom_mem[10] = 16'h8000;
        rom_mem[11] = 16'h0001;
        clear_rec();

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("reset_cpu_hold", cpu_hold, 1);
        check("reset_done", done, 0);

        // First copy: timing, boot window and RAM image; single-word instance runs alongside.
        pulse_start();
        wait_done(60);
        check_full_copy("run1");
        check("run1_boot_first", boot_first, 1);
        check("run1_boot_last", boot_last, 12);
        check("single_write_count", wr1_count, 1);
        check("single_write_addr", wr1_addr, 18);
        check("single_write_data", wr1_data, 16'h8000);
        check("single_write_cycle", wr1_cycle, 3);
        check("single_done_cycle", done1_cycle, 4);
`ifdef BOOT_CHECKSUM_EN
        check("checksum_main", checksum, 16'h4E62);
        check("checksum_single", checksum1, 16'h8000);
        check("checksum_wrap_done", done3, 1);
        check("checksum_wrap", checksum3, 16'h0001);
`endif

        // Restart from DONE with stray start pulses at cycles 2 and 5.
        pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(60);
        check_full_copy("run2");

        // Reset during the WRITE of the second word, then reset and start together.
        pulse_start();
        for (int n = 0; n < 20 && (edge_cnt - start_edge) != 6; n++) @(negedge clk);
        check("abort_in_write", ram_wr_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_cpu_hold", cpu_hold, 1);
        check("abort_busy", busy, 0);
        check("abort_ram_addr", ram_addr, 0);
        check("abort_ram_wdata", ram_wdata, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("reset_beats_start", busy, 0);
        check("reset_beats_start_hold", cpu_hold, 1);

        pulse_start();
        wait_done(60);
        check_full_copy("run3");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
